// File: rtl/pmem_acc_reader.sv
// Read-side sequencer for the psum SRAM: reads acc_len psums per output, accumulates
// them per lane, saturates to psum_bw with optional ReLU, and hands each vector out on valid/ready.
module pmem_acc_reader #(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8,
    parameter int unsigned addr_w  = 14,
    parameter int unsigned len_w   = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [addr_w-1:0]          base_addr,
    input  logic [addr_w-1:0]          num_out,
    input  logic [len_w-1:0]           acc_len,
    input  logic                       relu_en,
    output logic                       busy,
    output logic                       done,
    output logic                       pmem_CEN,
    output logic [addr_w-1:0]          pmem_A,
    input  logic [psum_bw*col-1:0]     pmem_Q,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [psum_bw*col-1:0]     out_data
);

    localparam int unsigned WW    = psum_bw * col;
    localparam int unsigned ACC_W = psum_bw + len_w;
    localparam int unsigned CNT_W = addr_w + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (psum_bw - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_TAIL,
        S_OUT,
        S_FINISH
    } state_t;

    state_t                  state_q;
    logic [addr_w-1:0]       addr_q;
    logic [addr_w-1:0]       num_q;
    logic [addr_w-1:0]       out_idx_q;
    logic [len_w-1:0]        len_q;
    logic [len_w-1:0]        term_q;
    logic                    relu_q;
    logic                    cen_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    out_valid_q;
    logic [WW-1:0]           out_data_q;
    logic                    vld_q;
    logic                    first_q;
    logic signed [ACC_W-1:0] acc_q   [col];

    logic signed [ACC_W-1:0] q_ext   [col];
    logic signed [ACC_W-1:0] acc_nxt [col];
    logic [psum_bw-1:0]      lane_sat [col];
    logic [WW-1:0]           sat_data;

    // Per-lane accumulate of the word landing this cycle, plus saturated/ReLU view of the result
    always_comb begin
        sat_data = '0;
        for (int i = 0; i < int'(col); i++) begin
            q_ext[i]   = {{len_w{pmem_Q[i*psum_bw+psum_bw-1]}}, pmem_Q[i*psum_bw +: psum_bw]};
            acc_nxt[i] = first_q ? q_ext[i] : acc_q[i] + q_ext[i];
            if (relu_q && acc_nxt[i][ACC_W-1]) begin
                lane_sat[i] = '0;
            end else if (acc_nxt[i] > SAT_MAX) begin
                lane_sat[i] = SAT_MAX[psum_bw-1:0];
            end else if (acc_nxt[i] < SAT_MIN) begin
                lane_sat[i] = SAT_MIN[psum_bw-1:0];
            end else begin
                lane_sat[i] = acc_nxt[i][psum_bw-1:0];
            end
            sat_data[i*psum_bw +: psum_bw] = lane_sat[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            num_q       <= '0;
            out_idx_q   <= '0;
            len_q       <= '0;
            term_q      <= '0;
            relu_q      <= 1'b0;
            cen_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            vld_q       <= 1'b0;
            first_q     <= 1'b0;
            for (int i = 0; i < int'(col); i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            done_q  <= 1'b0;
            // Read data is valid exactly one cycle after an issued read
            vld_q   <= ~cen_q;
            first_q <= (term_q == '0);
            if (vld_q) begin
                for (int i = 0; i < int'(col); i++) begin
                    acc_q[i] <= acc_nxt[i];
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q    <= base_addr;
                        num_q     <= num_out;
                        len_q     <= (acc_len == '0) ? len_w'(1) : acc_len;
                        relu_q    <= relu_en;
                        term_q    <= '0;
                        out_idx_q <= '0;
                        if (num_out == '0) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_READ;
                            busy_q  <= 1'b1;
                            cen_q   <= 1'b0;
                        end
                    end
                end
                S_READ: begin
                    addr_q <= addr_q + addr_w'(1);
                    if (term_q == len_q - len_w'(1)) begin
                        term_q  <= '0;
                        cen_q   <= 1'b1;
                        state_q <= S_TAIL;
                    end else begin
                        term_q <= term_q + len_w'(1);
                    end
                end
                S_TAIL: begin
                    out_data_q  <= sat_data;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if ((CNT_W'(out_idx_q) + CNT_W'(1)) < CNT_W'(num_q)) begin
                            out_idx_q <= out_idx_q + addr_w'(1);
                            cen_q     <= 1'b0;
                            state_q   <= S_READ;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pmem_CEN  = cen_q;
    assign pmem_A    = addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_pmem_acc_reader.sv
// Scoreboard bench for pmem_acc_reader: a pmem model serves reads, monitors check
// read addresses and output vectors against queued expectations.
module tb_pmem_acc_reader;

    localparam int unsigned PW  = 16;
    localparam int unsigned COL = 8;
    localparam int unsigned AW  = 14;
    localparam int unsigned LW  = 5;
    localparam int unsigned WW  = PW * COL;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_out;
    logic [LW-1:0] acc_len;
    logic          relu_en;
    logic          busy;
    logic          done;
    logic          pmem_CEN;
    logic [AW-1:0] pmem_A;
    logic [WW-1:0] pmem_Q = '0;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] out_data;

    pmem_acc_reader #(.psum_bw(PW), .col(COL), .addr_w(AW), .len_w(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_out(num_out), .acc_len(acc_len), .relu_en(relu_en), .busy(busy),
        .done(done), .pmem_CEN(pmem_CEN), .pmem_A(pmem_A), .pmem_Q(pmem_Q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    logic [WW-1:0] mem [2**AW];
    always @(posedge clk) if (!pmem_CEN) pmem_Q <= mem[pmem_A];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int start_cyc = 0;
    logic [AW-1:0] exp_addr [$];
    logic [WW-1:0] exp_data [$];

    task automatic check(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    function automatic logic [WW-1:0] rep(input int v);
        logic [WW-1:0] w;
        for (int i = 0; i < int'(COL); i++) w[i*PW +: PW] = PW'(v);
        return w;
    endfunction

    function automatic logic [WW-1:0] seq(input int off);
        logic [WW-1:0] w;
        for (int i = 0; i < int'(COL); i++) w[i*PW +: PW] = PW'(i + 1 + off);
        return w;
    endfunction

    // Monitors: every issued read and every accepted output is matched against the queues
    always @(negedge clk) begin
        if (reset) begin
            if (!pmem_CEN) begin
                if (exp_addr.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rd_addr: unexpected read at %0d, required no read", pmem_A);
                end else begin
                    check("rd_addr", WW'(pmem_A), WW'(exp_addr.pop_front()));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL out_data: unexpected output %h, required none", out_data);
                end else begin
                    check("out_data", out_data, exp_data.pop_front());
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] n,
                               input logic [LW-1:0] l, input logic r);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_out = n; acc_len = l; relu_en = r;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = ~b; num_out = n + AW'(3); acc_len = l + LW'(1); relu_en = ~r;
    endtask

    task automatic run_job(input logic [AW-1:0] b, input logic [AW-1:0] n, input logic [LW-1:0] l,
                           input logic r, input int lat_v_req, input int lat_d_req);
        int lat_v;
        int lat_d;
        lat_v = -1;
        lat_d = -1;
        pulse_start(b, n, l, r);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cyc - start_cyc == 1) check("busy_after_start", WW'(busy), WW'(n != '0));
            if (out_valid && lat_v < 0) lat_v = cyc - start_cyc;
            start = (cyc - start_cyc == 2);
            if (done) begin
                lat_d = cyc - start_cyc;
                break;
            end
        end
        start = 1'b0;
        check("first_valid_cycle", WW'(lat_v), WW'(lat_v_req));
        check("done_cycle", WW'(lat_d), WW'(lat_d_req));
        check("busy_at_done", WW'(busy), WW'(0));
        @(negedge clk);
        check("done_single_pulse", WW'(done), WW'(0));
        check("reads_pending", WW'(exp_addr.size()), WW'(0));
        check("outputs_pending", WW'(exp_data.size()), WW'(0));
    endtask

    initial begin
        int lat_d;
        int dc;
        reset = 1'b0; start = 1'b0; base_addr = '0; num_out = '0; acc_len = '0;
        relu_en = 1'b0; out_ready = 1'b1;
        for (int a = 0; a < 2**AW; a++) mem[a] = '0;
        mem[0] = seq(0);
        for (int a = 10; a < 16; a++) mem[a] = rep(100);
        mem[20] = rep(30000); mem[21] = rep(30000);
        mem[22] = rep(-30000); mem[23] = rep(-30000);
        for (int a = 100; a < 104; a++) mem[a] = rep(7);
        mem[2**AW - 1] = rep(5);

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", WW'(busy), WW'(0));
        check("rst_done", WW'(done), WW'(0));
        check("rst_cen", WW'(pmem_CEN), WW'(1));
        check("rst_addr", WW'(pmem_A), WW'(0));
        check("rst_valid", WW'(out_valid), WW'(0));
        check("rst_data", out_data, WW'(0));
        @(posedge clk); #1 reset = 1'b1;

        // single output, no accumulation
        exp_addr.push_back(0); exp_data.push_back(seq(0));
        run_job(0, 1, 1, 1'b0, 3, 4);

        // accumulation over three terms, two outputs
        for (int a = 10; a < 16; a++) exp_addr.push_back(AW'(a));
        exp_data.push_back(rep(300)); exp_data.push_back(rep(300));
        run_job(10, 2, 3, 1'b0, 5, 11);

        // saturation without and with ReLU
        for (int a = 20; a < 24; a++) exp_addr.push_back(AW'(a));
        exp_data.push_back(rep(32767)); exp_data.push_back(rep(-32768));
        run_job(20, 2, 2, 1'b0, 4, 9);
        for (int a = 20; a < 24; a++) exp_addr.push_back(AW'(a));
        exp_data.push_back(rep(32767)); exp_data.push_back(rep(0));
        run_job(20, 2, 2, 1'b1, 4, 9);

        // backpressure: consumer stalls the first output for five cycles
        for (int a = 10; a < 16; a++) exp_addr.push_back(AW'(a));
        exp_data.push_back(rep(300)); exp_data.push_back(rep(300));
        out_ready = 1'b0;
        pulse_start(10, 2, 3, 1'b0);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        check("bp_valid_cycle", WW'(cyc - start_cyc), WW'(5));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_held", WW'(out_valid), WW'(1));
            check("bp_data_held", out_data, rep(300));
            check("bp_no_read", WW'(pmem_CEN), WW'(1));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        lat_d = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                lat_d = cyc - start_cyc;
                break;
            end
        end
        check("bp_done_cycle", WW'(lat_d), WW'(17));
        check("bp_outputs_pending", WW'(exp_data.size()), WW'(0));

        // address wrap from the top of pmem to 0
        exp_addr.push_back(AW'(2**AW - 1)); exp_addr.push_back(0);
        exp_data.push_back(seq(5));
        run_job(AW'(2**AW - 1), 1, 2, 1'b0, 4, 5);

        // empty job
        run_job(50, 0, 3, 1'b0, -1, 1);

        // acc_len of zero acts as one
        exp_addr.push_back(10); exp_addr.push_back(11);
        exp_data.push_back(rep(100)); exp_data.push_back(rep(100));
        run_job(10, 2, 0, 1'b0, 3, 7);

        // reset while reading the second of three outputs
        for (int a = 100; a < 105; a++) exp_addr.push_back(AW'(a));
        exp_data.push_back(rep(28));
        pulse_start(100, 3, 4, 1'b0);
        repeat (7) @(posedge clk);
        #1 reset = 1'b0;
        dc = done_cnt;
        #1;
        check("mid_rst_cen", WW'(pmem_CEN), WW'(1));
        check("mid_rst_valid", WW'(out_valid), WW'(0));
        check("mid_rst_busy", WW'(busy), WW'(0));
        repeat (3) @(posedge clk);
        check("mid_rst_no_done", WW'(done_cnt), WW'(dc));
        check("mid_rst_reads", WW'(exp_addr.size()), WW'(0));
        check("mid_rst_outputs", WW'(exp_data.size()), WW'(0));
        #1 reset = 1'b1;

        exp_addr.push_back(0); exp_data.push_back(seq(0));
        run_job(0, 1, 1, 1'b0, 3, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pmem_acc_reader.md
Name: pmem_acc_reader

Overview:
Read-side sequencer for the psum SRAM (16384x128 pmem). It drives the pmem read port (CEN/A, WEN held high by the parent) and absorbs the 1-cycle read latency. It accumulates acc_len consecutive psum vectors per output and applies per-lane saturation and optional ReLU. Each finished output vector is presented to the SFP/output path on a valid/ready handshake. It sits beside the ofifo->pmem write path in core and closes the pmem-to-SFP connection.

Parameters:
psum_bw, 16, signed width of one psum lane and of each output lane
col, 8, number of lanes per pmem word (word width = psum_bw*col)
addr_w, 14, pmem address width
len_w, 5, width of acc_len; the internal accumulator is psum_bw+len_w bits per lane

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  single-cycle job request; ignored while busy=1
base_addr  in  addr_w  pmem address of the first psum of the job
num_out  in  addr_w  number of output vectors in the job
acc_len  in  len_w  psums summed per output; 0 is treated as 1
relu_en  in  1  1 = clamp negative lanes to 0 after saturation
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the job completes
pmem_CEN  out  1  pmem chip enable, active-low
pmem_A  out  addr_w  pmem read address
pmem_Q  in  psum_bw*col  pmem read data, valid the cycle after pmem_CEN=0
out_valid  out  1  out_data holds a finished vector
out_ready  in  1  consumer accepts out_data when out_valid and out_ready are both 1
out_data  out  psum_bw*col  finished vector; lane i occupies bits [psum_bw*(i+1)-1 : psum_bw*i]

Behaviour:
- Reset (reset=0, async): FSM=IDLE, busy=0, done=0, pmem_CEN=1, pmem_A=0, out_valid=0, out_data=0, accumulators=0. A reset mid-job aborts the job with no done pulse.
- Job start: on start=1 in IDLE, latch base_addr, num_out, acc_len (0->1) and relu_en. Later input changes do not affect the running job.
- num_out=0: go directly to FINISH, issue no reads, pulse done the next cycle.
- Address order:
  - output k, term j is read from (base_addr + k*len + j) mod 2^addr_w.
  - A single address counter increments by 1 per issued read and wraps from 2^addr_w-1 to 0.
- FSM states:
  - IDLE: wait for start.
  - READ:
    - Assert pmem_CEN=0 with pmem_A=counter every cycle, for len cycles per output.
    - Data arriving one cycle later is accumulated per lane: the first term loads the accumulator, later terms add to it.
    - After issuing the last term, go to TAIL.
  - TAIL: pmem_CEN=1; the last term arrives and is accumulated; go to OUT.
  - OUT:
    - out_valid=1.
    - out_data = per-lane saturation of the accumulator to the signed psum_bw range [-2^(psum_bw-1), 2^(psum_bw-1)-1], then ReLU if latched relu_en.
    - out_data is registered and held stable while out_valid=1 and out_ready=0.
    - On handshake: if k+1 < num_out, go to READ for the next output; otherwise go to FINISH.
  - FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Timing:
  - First pmem read is issued the cycle after start.
  - First out_valid is asserted len+2 cycles after start.
  - Minimum per-output period is len+2 cycles with out_ready tied high.
  - No reads are issued while in OUT; read data always lands in a non-stalled cycle.
- Arithmetic: psums are sign-extended to psum_bw+len_w bits. The accumulator cannot overflow for len ≤ 2^len_w-1. Saturation is applied only at output.
- start asserted in the same cycle as done, or while busy: ignored.

Test Plan:
- Single output, no accumulation: base_addr=0, num_out=1, acc_len=1, pmem[0] lanes=1..8, relu_en=0, out_ready=1 -> one read at addr 0, out_data lanes 1..8 at cycle 3, done pulse once, busy low after.
- Accumulation: acc_len=3, num_out=2, pmem[10..15] each lane = 100, base_addr=10 -> reads at 10..15 in order, two outputs with every lane = 300.
- Saturation and ReLU: acc_len=2, lanes 30000+30000 and -30000+-30000, relu_en=0 -> 32767 / -32768. Same data with relu_en=1 -> 32767 / 0.
- Backpressure: out_ready held 0 for 5 cycles while in OUT -> out_valid stays 1, out_data unchanged, pmem_CEN stays 1, next read only after the handshake.
- Wrap-around and edge cases:
  - base_addr=16383, acc_len=2, num_out=1 -> reads at 16383 then 0.
  - num_out=0 -> no reads, done pulse 1 cycle after start.
  - acc_len=0 -> behaves as acc_len=1.
- Reset mid-job: reset=0 during READ of output 1 of 3 -> pmem_CEN=1, out_valid=0, busy=0 immediately, no done pulse. A new start after reset release runs correctly from its own base_addr.
